xlr8_tone_gen: RTL and testbench

- Multi-channel square-wave tone generator XB on the AVR data-memory register bus.
- Replaces the fixed two-pin on/off speaker block.
- Each channel has its own programmable half-period and a finite or continuous tone length, so firmware can play notes without bit-banging.
- A global enable, per-channel start/stop and a status register complete the programming model; outputs drive speaker pins directly.

---
 rtl/xlr8_tone_gen.sv | 201 ++++++++++++++++++++
 tb/tb_xlr8_tone_gen.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xlr8_tone_gen.sv
// Multi-channel square-wave tone generator on the AVR data-memory register bus.
// Each channel toggles its speaker pin every `div` timing ticks. A channel runs
// for a fixed number of periods, or until it is stopped when the duration is 0.
// A shared prescaler divides clken-qualified clocks down to timing ticks.
module xlr8_tone_gen #(
  parameter logic [7:0] CTRL_ADDR = 8'h00,
  parameter logic [7:0] SEL_ADDR  = 8'h00,
  parameter logic [7:0] DIVL_ADDR = 8'h00,
  parameter logic [7:0] DIVH_ADDR = 8'h00,
  parameter logic [7:0] DUR_ADDR  = 8'h00,
  parameter logic [7:0] STAT_ADDR = 8'h00,
  parameter int         NUM_CH    = 4,
  parameter int         PRESCALE  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clken,
  input  logic [7:0]        dbus_in,
  output logic [7:0]        dbus_out,
  output logic              io_out_en,
  input  logic [7:0]        ramadr,
  input  logic              ramre,
  input  logic              ramwe,
  input  logic              dm_sel,
  output logic [NUM_CH-1:0] spk_out
);

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  // Programming-model registers
  logic              r_gen_en;
  logic [7:0]        r_sel;
  logic [7:0]        r_divl;
  logic [PS_W-1:0]   r_ps;

  // Per-channel state
  logic [15:0]       r_div  [NUM_CH];
  logic [15:0]       r_hcnt [NUM_CH];
  logic [7:0]        r_rem  [NUM_CH];
  logic [NUM_CH-1:0] r_run;
  logic [NUM_CH-1:0] r_spk;

  // Bus decode
  logic        w_wr;
  logic        w_rd;
  logic        w_wr_ctrl;
  logic        w_wr_sel;
  logic        w_wr_divl;
  logic        w_wr_divh;
  logic        w_wr_dur;
  logic        w_gen_nxt;
  logic        w_stop_sel;
  logic [15:0] w_div_new;
  logic        w_tick;

  assign w_wr       = clken && ramwe && dm_sel;
  assign w_rd       = dm_sel && ramre;
  assign w_wr_ctrl  = w_wr && (ramadr == CTRL_ADDR);
  assign w_wr_sel   = w_wr && (ramadr == SEL_ADDR);
  assign w_wr_divl  = w_wr && (ramadr == DIVL_ADDR);
  assign w_wr_divh  = w_wr && (ramadr == DIVH_ADDR);
  assign w_wr_dur   = w_wr && (ramadr == DUR_ADDR);
  // GEN_EN as it will be after this edge; clearing it idles channels on the same edge
  assign w_gen_nxt  = w_wr_ctrl ? dbus_in[0] : r_gen_en;
  assign w_stop_sel = w_wr_ctrl && dbus_in[1];
  assign w_div_new  = {dbus_in, r_divl};
  assign w_tick     = r_gen_en && clken && (r_ps == PS_LAST);

  // Per-channel next-state qualifiers. Selection by equality with the channel
  // index means an out-of-range SEL never matches, so such writes fall away.
  logic [NUM_CH-1:0] w_kill;
  logic [NUM_CH-1:0] w_start;
  logic [NUM_CH-1:0] w_cmp;

  // Decode stop/start/compare conditions for each channel
  always_comb begin
    w_kill  = '0;
    w_start = '0;
    w_cmp   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_kill[i]  = !w_gen_nxt
                || (w_stop_sel && (r_sel == 8'(i)))
                || (w_wr_divh && (r_sel == 8'(i)) && (w_div_new == 16'd0));
      w_start[i] = w_wr_dur && (r_sel == 8'(i)) && r_gen_en && (r_div[i] != 16'd0);
      // hcnt+1 >= div is hcnt >= div-1 without underflow; >= avoids lockup after a shrink
      w_cmp[i]   = ({1'b0, r_hcnt[i]} + 17'd1) >= {1'b0, r_div[i]};
    end
  end

  // Control registers: CTRL.GEN_EN, SEL and the staged divider low byte
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_gen_en <= 1'b0;
      r_sel    <= 8'h00;
      r_divl   <= 8'h00;
    end else begin
      if (w_wr_ctrl) r_gen_en <= dbus_in[0];
      if (w_wr_sel)  r_sel    <= dbus_in;
      if (w_wr_divl) r_divl   <= dbus_in;
    end
  end

  // Global prescaler: free-running while enabled, held at 0 while GEN_EN=0
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ps <= '0;
    end else if (!r_gen_en) begin
      r_ps <= '0;
    end else if (clken) begin
      r_ps <= (r_ps == PS_LAST) ? '0 : r_ps + 1'b1;
    end
  end

  // Divider commit: DIVH write latches {DIVH, staged DIVL} into the selected channel
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) r_div[i] <= 16'd0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wr_divh && (r_sel == 8'(i))) r_div[i] <= w_div_new;
      end
    end
  end

  // Channel IDLE/RUN machines: stop beats start, start beats a timing tick
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_run <= '0;
      r_spk <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_hcnt[i] <= 16'd0;
        r_rem[i]  <= 8'd0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_kill[i]) begin
          r_run[i]  <= 1'b0;
          r_spk[i]  <= 1'b0;
          r_hcnt[i] <= 16'd0;
          r_rem[i]  <= 8'd0;
        end else if (w_start[i]) begin
          r_run[i]  <= 1'b1;
          r_spk[i]  <= 1'b1;
          r_hcnt[i] <= 16'd0;
          r_rem[i]  <= dbus_in;
        end else if (r_run[i] && w_tick) begin
          if (w_cmp[i]) begin
            r_hcnt[i] <= 16'd0;
            r_spk[i]  <= ~r_spk[i];
            // Falling edge closes one period; the last one ends the tone with spk low
            if (r_spk[i] && (r_rem[i] != 8'd0)) begin
              r_rem[i] <= r_rem[i] - 8'd1;
              if (r_rem[i] == 8'd1) r_run[i] <= 1'b0;
            end
          end else begin
            r_hcnt[i] <= r_hcnt[i] + 16'd1;
          end
        end
      end
    end
  end

  // Selected-channel readback values and the running-status vector
  logic [15:0] w_sel_div;
  logic [7:0]  w_sel_rem;
  logic [7:0]  w_stat;

  // Gather per-channel values addressed by SEL; out-of-range SEL leaves them 0
  always_comb begin
    w_sel_div = 16'd0;
    w_sel_rem = 8'd0;
    w_stat    = 8'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_sel == 8'(i)) begin
        w_sel_div = r_div[i];
        w_sel_rem = r_rem[i];
      end
      w_stat[i] = r_run[i];
    end
  end

  // Combinational read mux; io_out_en flags any read of an owned address
  always_comb begin
    dbus_out  = 8'h00;
    io_out_en = 1'b0;
    if (w_rd) begin
      io_out_en = 1'b1;
      if (ramadr == CTRL_ADDR)      dbus_out = {7'd0, r_gen_en};
      else if (ramadr == SEL_ADDR)  dbus_out = r_sel;
      else if (ramadr == DIVL_ADDR) dbus_out = w_sel_div[7:0];
      else if (ramadr == DIVH_ADDR) dbus_out = w_sel_div[15:8];
      else if (ramadr == DUR_ADDR)  dbus_out = w_sel_rem;
      else if (ramadr == STAT_ADDR) dbus_out = w_stat;
      else                          io_out_en = 1'b0;
    end
  end

  assign spk_out = r_spk;

endmodule

// File: tb/tb_xlr8_tone_gen.sv
// Testbench for xlr8_tone_gen: directed scenario tasks plus a randomized run
// checked against a tick-count model of the channel behaviour.
module tb_xlr8_tone_gen;

  localparam int         NCH    = 4;
  localparam int         P      = 2;
  localparam logic [7:0] A_CTRL = 8'h20;
  localparam logic [7:0] A_SEL  = 8'h21;
  localparam logic [7:0] A_DIVL = 8'h22;
  localparam logic [7:0] A_DIVH = 8'h23;
  localparam logic [7:0] A_DUR  = 8'h24;
  localparam logic [7:0] A_STAT = 8'h25;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           clken = 1'b1;
  logic [7:0]     dbus_in = 8'h00;
  logic [7:0]     dbus_out;
  logic           io_out_en;
  logic [7:0]     ramadr = 8'h00;
  logic           ramre = 1'b0;
  logic           ramwe = 1'b0;
  logic           dm_sel = 1'b0;
  logic [NCH-1:0] spk_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  xlr8_tone_gen #(
    .CTRL_ADDR(A_CTRL), .SEL_ADDR(A_SEL), .DIVL_ADDR(A_DIVL),
    .DIVH_ADDR(A_DIVH), .DUR_ADDR(A_DUR), .STAT_ADDR(A_STAT),
    .NUM_CH(NCH), .PRESCALE(P)
  ) dut (
    .clk(clk), .rstn(rstn), .clken(clken), .dbus_in(dbus_in), .dbus_out(dbus_out),
    .io_out_en(io_out_en), .ramadr(ramadr), .ramre(ramre), .ramwe(ramwe),
    .dm_sel(dm_sel), .spk_out(spk_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // Ticks happen every P edges counted from the edge that enabled the generator.
  // A channel started at edge s has seen floor(ticks/div) toggles; it begins
  // high, and with a finite duration r it ends after its r-th falling toggle.
  bit          m_gen = 0;
  int          m_en_edge = 0;
  logic [7:0]  m_sel = 0;
  logic [15:0] m_div [NCH];
  bit          m_act [NCH];
  int          m_start [NCH];
  int          m_cdiv [NCH];
  int          m_r [NCH];
  int          m_last = 0;

  function automatic int tk(int n);
    return (n - m_en_edge) / P;
  endfunction

  function automatic int toggles(int ch, int n);
    return (tk(n) - tk(m_start[ch])) / m_cdiv[ch];
  endfunction

  function automatic bit e_run(int ch, int n);
    if (!m_act[ch]) return 1'b0;
    if (m_r[ch] == 0) return 1'b1;
    return ((toggles(ch, n) + 1) / 2) < m_r[ch];
  endfunction

  function automatic bit e_spk(int ch, int n);
    if (!e_run(ch, n)) return 1'b0;
    return (toggles(ch, n) % 2) == 0;
  endfunction

  function automatic int e_rem(int ch, int n);
    if (!e_run(ch, n) || m_r[ch] == 0) return 0;
    return m_r[ch] - (toggles(ch, n) + 1) / 2;
  endfunction

  function automatic logic [NCH-1:0] e_spkv(int n);
    logic [NCH-1:0] v = '0;
    for (int ch = 0; ch < NCH; ch++) v[ch] = e_spk(ch, n);
    return v;
  endfunction

  function automatic logic [7:0] e_stat(int n);
    logic [7:0] v = '0;
    for (int ch = 0; ch < NCH; ch++) v[ch] = e_run(ch, n);
    return v;
  endfunction

  function automatic logic [7:0] e_dur(int n);
    if (int'(m_sel) >= NCH) return 8'h00;
    return 8'(e_rem(int'(m_sel), n));
  endfunction

  task automatic model_reset();
    m_gen = 0; m_sel = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      m_div[ch] = 0; m_act[ch] = 0; m_start[ch] = 0; m_cdiv[ch] = 1; m_r[ch] = 0;
    end
  endtask

  // ---------------- bus access ----------------
  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    ramadr = a; dbus_in = d; ramwe = 1'b1; dm_sel = 1'b1;
    @(posedge clk);
    #1;
    m_last = cyc;
    ramwe = 1'b0; dm_sel = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic en);
    @(negedge clk);
    ramadr = a; ramre = 1'b1; dm_sel = 1'b1;
    #1;
    d = dbus_out; en = io_out_en;
    ramre = 1'b0; dm_sel = 1'b0;
  endtask

  task automatic wr_ctrl(input logic [7:0] d);
    bus_write(A_CTRL, d);
    if (d[0] && !m_gen) m_en_edge = m_last;
    if (!d[0]) for (int ch = 0; ch < NCH; ch++) m_act[ch] = 0;
    if (d[1] && int'(m_sel) < NCH) m_act[int'(m_sel)] = 0;
    m_gen = d[0];
  endtask

  task automatic wr_sel(input logic [7:0] d);
    bus_write(A_SEL, d);
    m_sel = d;
  endtask

  task automatic wr_div(input logic [15:0] v);
    bus_write(A_DIVL, v[7:0]);
    bus_write(A_DIVH, v[15:8]);
    if (int'(m_sel) < NCH) begin
      m_div[int'(m_sel)] = v;
      if (v == 16'd0) m_act[int'(m_sel)] = 0;
    end
  endtask

  task automatic wr_dur(input logic [7:0] d);
    bus_write(A_DUR, d);
    if (int'(m_sel) < NCH && m_gen && m_div[int'(m_sel)] != 16'd0) begin
      m_act[int'(m_sel)]   = 1;
      m_start[int'(m_sel)] = m_last;
      m_cdiv[int'(m_sel)]  = int'(m_div[int'(m_sel)]);
      m_r[int'(m_sel)]     = int'(d);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [7:0] d; logic en;
    logic [7:0] addrs [6];
    addrs = '{A_CTRL, A_SEL, A_DIVL, A_DIVH, A_DUR, A_STAT};
    rstn = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (spk_out !== '0) begin errors++; $display("FAIL reset_spk got=%b exp=0", spk_out); end
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus_read(addrs[i], d, en);
      checks++;
      if (d !== 8'h00 || en !== 1'b1) begin
        errors++; $display("FAIL reset_read addr=%h got=%h en=%b exp=00 en=1", addrs[i], d, en);
      end
    end
    @(negedge clk);
    ramadr = A_CTRL; dm_sel = 1'b1; ramre = 1'b0; #1;
    checks++;
    if (io_out_en !== 1'b0 || dbus_out !== 8'h00) begin
      errors++; $display("FAIL no_read_en got en=%b d=%h exp en=0 d=00", io_out_en, dbus_out);
    end
    dm_sel = 1'b0;
    wr_ctrl(8'h01); wr_sel(8'h02); wr_div(16'h1234);
    bus_read(A_DIVL, d, en); checks++;
    if (d !== 8'h34) begin errors++; $display("FAIL readback_divl got=%h exp=34", d); end
    bus_read(A_DIVH, d, en); checks++;
    if (d !== 8'h12) begin errors++; $display("FAIL readback_divh got=%h exp=12", d); end
    bus_read(A_CTRL, d, en); checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL readback_ctrl got=%h exp=01", d); end
    bus_read(A_SEL, d, en); checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL readback_sel got=%h exp=02", d); end
    bus_write(A_DIVL, 8'h56);
    bus_read(A_DIVL, d, en); checks++;
    if (d !== 8'h34) begin errors++; $display("FAIL staged_not_visible got=%h exp=34", d); end
  endtask

  task automatic test_finite();
    logic sp, st, prev_sp, prev_st, st_f2, st_pre_f2;
    logic [7:0] dur0;
    int s, nfall, nrise, f1, r2, f2;
    wr_sel(8'd0); wr_div(16'd3); wr_dur(8'd2);
    s = m_last;
    prev_sp = 1'b1; prev_st = 1'b1; nfall = 0; nrise = 0; f1 = -100; r2 = -100; f2 = -100;
    st_f2 = 1'b1; st_pre_f2 = 1'b0; dur0 = 8'h00; sp = 1'b0; st = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      ramadr = A_STAT; ramre = 1'b1; dm_sel = 1'b1; #1;
      sp = spk_out[0]; st = dbus_out[0];
      if (c == 0) begin ramadr = A_DUR; #1; dur0 = dbus_out; end
      ramre = 1'b0; dm_sel = 1'b0;
      if (c == 0) begin
        checks++;
        if (sp !== 1'b1 || st !== 1'b1) begin
          errors++; $display("FAIL finite_start got spk=%b stat0=%b exp 1/1", sp, st);
        end
      end
      if (prev_sp && !sp) begin
        nfall++;
        if (nfall == 1) f1 = cyc;
        else if (nfall == 2) begin f2 = cyc; st_f2 = st; st_pre_f2 = prev_st; end
      end
      if (!prev_sp && sp) begin nrise++; if (nrise == 1) r2 = cyc; end
      prev_sp = sp; prev_st = st;
    end
    checks++;
    if (dur0 !== 8'd2) begin errors++; $display("FAIL finite_dur_read got=%0d exp=2", dur0); end
    checks++;
    if (nfall != 2 || nrise != 1) begin
      errors++; $display("FAIL finite_periods got falls=%0d rises=%0d exp 2/1", nfall, nrise);
    end
    checks++;
    if ((f1 - s) < 5 || (f1 - s) > 6) begin
      errors++; $display("FAIL finite_first_half got=%0d exp 5..6", f1 - s);
    end
    checks++;
    if ((r2 - f1) != 6) begin errors++; $display("FAIL finite_low_half got=%0d exp=6", r2 - f1); end
    checks++;
    if ((f2 - r2) != 6) begin errors++; $display("FAIL finite_high_half got=%0d exp=6", f2 - r2); end
    checks++;
    if (st_f2 !== 1'b0 || st_pre_f2 !== 1'b1) begin
      errors++; $display("FAIL finite_stat_clear got at=%b before=%b exp 0/1", st_f2, st_pre_f2);
    end
    checks++;
    if (sp !== 1'b0 || st !== 1'b0) begin
      errors++; $display("FAIL finite_after got spk=%b stat0=%b exp 0/0", sp, st);
    end
  endtask

  task automatic test_continuous_stop();
    logic sp, prev_sp; logic [7:0] d; logic en; int tr[$]; int bad;
    wr_sel(8'd1); wr_div(16'd1); wr_dur(8'd0);
    prev_sp = 1'b1; bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      sp = spk_out[1];
      if (sp !== prev_sp) tr.push_back(cyc);
      prev_sp = sp;
    end
    for (int i = 1; i < tr.size(); i++) if (tr[i] - tr[i-1] != 2) bad++;
    checks++;
    if (bad != 0 || tr.size() < 12) begin
      errors++; $display("FAIL cont_toggle got transitions=%0d bad_gaps=%0d exp >=12/0", tr.size(), bad);
    end
    bus_read(A_STAT, d, en); checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL cont_stat got=%h exp=02", d); end
    wr_ctrl(8'h03);
    bus_read(A_STAT, d, en); checks++;
    if (d !== 8'h00 || spk_out[1] !== 1'b0) begin
      errors++; $display("FAIL stop_sel got stat=%h spk1=%b exp 00/0", d, spk_out[1]);
    end
    bus_read(A_CTRL, d, en); checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL stop_ctrl_read got=%h exp=01", d); end
  endtask

  task automatic test_multichannel();
    logic p0, p3; logic [7:0] d; logic en; int t0[$]; int t3[$]; int bad0, bad3, statbad;
    wr_sel(8'd0); wr_div(16'd2); wr_dur(8'd0);
    wr_sel(8'd3); wr_div(16'd5); wr_dur(8'd0);
    @(negedge clk); #1;
    p0 = spk_out[0]; p3 = spk_out[3]; bad0 = 0; bad3 = 0; statbad = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      ramadr = A_STAT; ramre = 1'b1; dm_sel = 1'b1; #1;
      if (dbus_out !== 8'h09) statbad++;
      ramre = 1'b0; dm_sel = 1'b0;
      if (spk_out[0] !== p0) t0.push_back(cyc);
      if (spk_out[3] !== p3) t3.push_back(cyc);
      p0 = spk_out[0]; p3 = spk_out[3];
    end
    for (int i = 1; i < t0.size(); i++) if (t0[i] - t0[i-1] != 4) bad0++;
    for (int i = 1; i < t3.size(); i++) if (t3[i] - t3[i-1] != 10) bad3++;
    checks++;
    if (bad0 != 0 || t0.size() < 15) begin
      errors++; $display("FAIL multi_ch0 got transitions=%0d bad_gaps=%0d exp >=15/0", t0.size(), bad0);
    end
    checks++;
    if (bad3 != 0 || t3.size() < 6) begin
      errors++; $display("FAIL multi_ch3 got transitions=%0d bad_gaps=%0d exp >=6/0", t3.size(), bad3);
    end
    checks++;
    if (statbad != 0) begin errors++; $display("FAIL multi_stat got %0d samples != 09 exp 0", statbad); end
    wr_ctrl(8'h00);
    bus_read(A_STAT, d, en); checks++;
    if (d !== 8'h00 || spk_out !== '0) begin
      errors++; $display("FAIL gen_off got stat=%h spk=%b exp 00/0000", d, spk_out);
    end
  endtask

  task automatic test_edge_cases();
    logic [7:0] d; logic en;
    clken = 1'b0;
    bus_write(A_SEL, 8'h05);
    clken = 1'b1;
    bus_read(A_SEL, d, en); checks++;
    if (d !== 8'h03) begin errors++; $display("FAIL clken_gate got=%h exp=03", d); end
    wr_ctrl(8'h01);
    wr_sel(8'd0); wr_div(16'd2); wr_dur(8'd0);
    wr_sel(8'd7); wr_div(16'h0505); wr_dur(8'd3);
    bus_read(A_STAT, d, en); checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL sel7_stat got=%h exp=01", d); end
    bus_read(A_DIVH, d, en); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL sel7_divh got=%h exp=00", d); end
    bus_read(A_DIVL, d, en); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL sel7_divl got=%h exp=00", d); end
    bus_read(A_DUR, d, en); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL sel7_dur got=%h exp=00", d); end
    wr_sel(8'd3);
    bus_read(A_DIVL, d, en); checks++;
    if (d !== 8'h05) begin errors++; $display("FAIL sel7_no_alias got=%h exp=05", d); end
    wr_sel(8'd0); wr_div(16'd0);
    bus_read(A_STAT, d, en); checks++;
    if (d !== 8'h00 || spk_out[0] !== 1'b0) begin
      errors++; $display("FAIL divh_zero_stop got stat=%h spk0=%b exp 00/0", d, spk_out[0]);
    end
    wr_dur(8'd4);
    bus_read(A_STAT, d, en); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL div0_no_start got=%h exp=00", d); end
    wr_sel(8'd1); wr_ctrl(8'h00); wr_dur(8'd2);
    bus_read(A_STAT, d, en); checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL gen0_no_start got=%h exp=00", d); end
    wr_ctrl(8'h01);
  endtask

  task automatic test_random();
    logic [7:0] ch, r; logic [15:0] dv; int win;
    for (int it = 0; it < 12; it++) begin
      ch = 8'($urandom_range(0, 5));
      dv = 16'($urandom_range(1, 4));
      r  = 8'($urandom_range(0, 3));
      if (it == 6) begin wr_ctrl(8'h00); wr_ctrl(8'h01); end
      wr_sel(ch);
      if (int'(ch) < NCH) wr_ctrl(8'h03);
      wr_div(dv); wr_dur(r);
      win = $urandom_range(10, 40);
      for (int c = 0; c < win; c++) begin
        @(negedge clk);
        ramadr = A_STAT; ramre = 1'b1; dm_sel = 1'b1; #1;
        checks++;
        if (spk_out !== e_spkv(cyc)) begin
          errors++; $display("FAIL rand_spk it=%0d cyc=%0d got=%b exp=%b", it, cyc, spk_out, e_spkv(cyc));
        end
        checks++;
        if (dbus_out !== e_stat(cyc)) begin
          errors++; $display("FAIL rand_stat it=%0d cyc=%0d got=%h exp=%h", it, cyc, dbus_out, e_stat(cyc));
        end
        ramadr = A_DUR; #1;
        checks++;
        if (dbus_out !== e_dur(cyc)) begin
          errors++; $display("FAIL rand_dur it=%0d cyc=%0d got=%h exp=%h", it, cyc, dbus_out, e_dur(cyc));
        end
        ramre = 1'b0; dm_sel = 1'b0;
      end
    end
  endtask

  task automatic test_reset_midtone();
    logic [7:0] d; logic en;
    logic [7:0] addrs [6];
    addrs = '{A_CTRL, A_SEL, A_DIVL, A_DIVH, A_DUR, A_STAT};
    wr_sel(8'd1); wr_div(16'd4); wr_dur(8'd0);
    @(negedge clk); #1;
    checks++;
    if (spk_out[1] !== 1'b1) begin errors++; $display("FAIL midtone_pre got spk1=%b exp=1", spk_out[1]); end
    #1 rstn = 1'b0;
    #1;
    checks++;
    if (spk_out !== '0) begin errors++; $display("FAIL async_reset got spk=%b exp=0000", spk_out); end
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus_read(addrs[i], d, en);
      checks++;
      if (d !== 8'h00) begin errors++; $display("FAIL post_reset_read addr=%h got=%h exp=00", addrs[i], d); end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (spk_out !== '0) begin errors++; $display("FAIL post_reset_spk got=%b exp=0000", spk_out); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_finite();
    test_continuous_stop();
    test_multichannel();
    test_edge_cases();
    test_random();
    test_reset_midtone();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
